ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between N_PORTS requesters, using fixed-priority or round-robin arbitration.
// Read responses come back through a latency-matched pipeline that holds {valid, port}.
module ram_arbiter #(
    parameter int N_PORTS     = 2,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 32,
    parameter int ARB_MODE    = 1,
    parameter int MEM_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_PORTS-1:0]              req_en,
    input  logic [N_PORTS-1:0]              req_we,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0] req_be,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   req_wdata,
    output logic [N_PORTS-1:0]              req_grant,
    output logic [N_PORTS-1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH/8-1:0]         mem_be,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_RESET = IDX_WIDTH'(N_PORTS - 1);

    logic [IDX_WIDTH-1:0] r_lastGrant;
    logic [IDX_WIDTH-1:0] w_grantIdx;
    logic                 w_anyGrant;
    logic                 w_readGrant;
    int                   w_candidate;

    logic [MEM_LATENCY-1:0] r_pipeValid;
    logic [IDX_WIDTH-1:0]   r_pipePort [MEM_LATENCY];

    // Descending loops: the last match written is the one that wins, so no early exit is needed.
    always_comb begin
        w_grantIdx  = '0;
        w_anyGrant  = 1'b0;
        w_candidate = 0;
        if (!reset) begin
            if (ARB_MODE == 0) begin
                for (int i = N_PORTS - 1; i >= 0; i--) begin
                    if (req_en[i]) begin
                        w_grantIdx = IDX_WIDTH'(i);
                        w_anyGrant = 1'b1;
                    end
                end
            end else begin
                for (int k = N_PORTS; k >= 1; k--) begin
                    w_candidate = int'(r_lastGrant) + k;
                    if (w_candidate >= N_PORTS) begin
                        w_candidate = w_candidate - N_PORTS;
                    end
                    for (int j = 0; j < N_PORTS; j++) begin
                        if (j == w_candidate && req_en[j]) begin
                            w_grantIdx = IDX_WIDTH'(j);
                            w_anyGrant = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        req_grant = '0;
        mem_en    = w_anyGrant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_anyGrant && w_grantIdx == IDX_WIDTH'(i)) begin
                req_grant[i] = 1'b1;
                mem_we       = req_we[i];
                mem_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_be       = req_be[i*BE_WIDTH +: BE_WIDTH];
                mem_wdata    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_readGrant = w_anyGrant && !mem_we;

    // Idle cycles keep last_grant so the rotation resumes where it left off.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastGrant <= LAST_RESET;
        end else if (w_anyGrant) begin
            r_lastGrant <= w_grantIdx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipeValid <= '0;
            for (int s = 0; s < MEM_LATENCY; s++) begin
                r_pipePort[s] <= '0;
            end
        end else begin
            r_pipeValid[0] <= w_readGrant;
            r_pipePort[0]  <= w_grantIdx;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                r_pipeValid[s] <= r_pipeValid[s-1];
                r_pipePort[s]  <= r_pipePort[s-1];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_rdata = '0;
        if (!reset && r_pipeValid[MEM_LATENCY-1]) begin
            resp_rdata = mem_rdata;
            for (int i = 0; i < N_PORTS; i++) begin
                if (r_pipePort[MEM_LATENCY-1] == IDX_WIDTH'(i)) begin
                    resp_valid[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a table-driven round-robin instance (3 ports, read latency 2)
// and a hand-written sequence on a fixed-priority instance (2 ports, read latency 1).
module tb_ram_arbiter;

    typedef struct packed {
        logic        rst;
        logic [2:0]  en;
        logic [2:0]  we;
        logic [2:0]  expGrant;
        logic [2:0]  expResp;
        logic [31:0] expRdata;
    } vec_t;

    localparam int NUM_VEC = 33;

    logic clk;
    logic preload;
    int   nVectors;
    int   nMiscompares;
    int   nCompares;

    // Round-robin instance signals
    logic        rstRr;
    logic [2:0]  rrEn, rrWe;
    logic [38:0] rrAddr;
    logic [11:0] rrBe;
    logic [95:0] rrWdata;
    logic [2:0]  rrGrant, rrRespValid;
    logic [31:0] rrRespRdata;
    logic        rrMemEn, rrMemWe;
    logic [12:0] rrMemAddr;
    logic [3:0]  rrMemBe;
    logic [31:0] rrMemWdata, rrMemRdata;
    logic [31:0] ramRr [0:63];
    logic [31:0] rrRd0, rrRd1;

    // Fixed-priority instance signals
    logic        rstFp;
    logic [1:0]  fpEn, fpWe;
    logic [25:0] fpAddr;
    logic [7:0]  fpBe;
    logic [63:0] fpWdata;
    logic [1:0]  fpGrant, fpRespValid;
    logic [31:0] fpRespRdata;
    logic        fpMemEn, fpMemWe;
    logic [12:0] fpMemAddr;
    logic [3:0]  fpMemBe;
    logic [31:0] fpMemWdata, fpMemRdata;
    logic [31:0] ramFp [0:7];
    logic [31:0] fpRd0;

    vec_t vecs [NUM_VEC];

    ram_arbiter #(.N_PORTS(3), .ADDR_WIDTH(13), .DATA_WIDTH(32), .ARB_MODE(1), .MEM_LATENCY(2)) dutRr (
        .clk(clk), .reset(rstRr),
        .req_en(rrEn), .req_we(rrWe), .req_addr(rrAddr), .req_be(rrBe), .req_wdata(rrWdata),
        .req_grant(rrGrant), .resp_valid(rrRespValid), .resp_rdata(rrRespRdata),
        .mem_en(rrMemEn), .mem_we(rrMemWe), .mem_addr(rrMemAddr), .mem_be(rrMemBe),
        .mem_wdata(rrMemWdata), .mem_rdata(rrMemRdata)
    );

    ram_arbiter #(.N_PORTS(2), .ADDR_WIDTH(13), .DATA_WIDTH(32), .ARB_MODE(0), .MEM_LATENCY(1)) dutFp (
        .clk(clk), .reset(rstFp),
        .req_en(fpEn), .req_we(fpWe), .req_addr(fpAddr), .req_be(fpBe), .req_wdata(fpWdata),
        .req_grant(fpGrant), .resp_valid(fpRespValid), .resp_rdata(fpRespRdata),
        .mem_en(fpMemEn), .mem_we(fpMemWe), .mem_addr(fpMemAddr), .mem_be(fpMemBe),
        .mem_wdata(fpMemWdata), .mem_rdata(fpMemRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-enabled RAM model with a two-stage read pipeline
    always @(posedge clk) begin
        if (preload) begin
            ramRr[5]  <= 32'hAAAAAAAA;
            ramRr[16] <= 32'hDEADBEEF;
            ramRr[32] <= 32'h22222222;
        end else if (rrMemEn) begin
            if (rrMemWe) begin
                for (int b = 0; b < 4; b++) begin
                    if (rrMemBe[b]) ramRr[rrMemAddr[5:0]][b*8 +: 8] <= rrMemWdata[b*8 +: 8];
                end
            end else begin
                rrRd0 <= ramRr[rrMemAddr[5:0]];
            end
        end
        rrRd1 <= rrRd0;
    end
    assign rrMemRdata = rrRd1;

    always @(posedge clk) begin
        if (preload) begin
            ramFp[3] <= 32'h33333333;
            ramFp[4] <= 32'h44444444;
        end else if (fpMemEn && !fpMemWe) begin
            fpRd0 <= ramFp[fpMemAddr[2:0]];
        end
    end
    assign fpMemRdata = fpRd0;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompares++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rstRr = v.rst;
        rrEn  = v.en;
        rrWe  = v.we;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        logic [12:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic        expWe;
        string       tag;
        @(negedge clk);
        nVectors++;
        tag      = $sformatf("rr[%0d]", idx);
        expAddr  = '0;
        expBe    = '0;
        expWdata = '0;
        expWe    = |(v.expGrant & v.we);
        if (v.expGrant[0]) begin
            expAddr = 13'h005; expBe = 4'h3; expWdata = 32'h11223344;
        end else if (v.expGrant[1]) begin
            expAddr = 13'h010; expBe = 4'hF; expWdata = 32'h0BADF00D;
        end else if (v.expGrant[2]) begin
            expAddr = 13'h020; expBe = 4'hF; expWdata = 32'h55667788;
        end
        compare({tag, " grant"},      32'(rrGrant),     32'(v.expGrant));
        compare({tag, " mem_en"},     32'(rrMemEn),     32'(|v.expGrant));
        compare({tag, " mem_we"},     32'(rrMemWe),     32'(expWe));
        compare({tag, " mem_addr"},   32'(rrMemAddr),   32'(expAddr));
        compare({tag, " mem_be"},     32'(rrMemBe),     32'(expBe));
        compare({tag, " mem_wdata"},  rrMemWdata,       expWdata);
        compare({tag, " resp_valid"}, 32'(rrRespValid), 32'(v.expResp));
        if (v.expResp != 3'b000 || v.rst) begin
            compare({tag, " resp_rdata"}, rrRespRdata, v.expRdata);
        end
    endtask

    task automatic applyStimulusFp(input logic rst, input logic [1:0] en);
        @(posedge clk);
        #1;
        rstFp = rst;
        fpEn  = en;
    endtask

    task automatic checkOutputFp(input int idx, input logic [1:0] expGrant, input logic [1:0] expResp,
                                 input logic [31:0] expRdata);
        string tag;
        @(negedge clk);
        nVectors++;
        tag = $sformatf("fp[%0d]", idx);
        compare({tag, " grant"},      32'(fpGrant),     32'(expGrant));
        compare({tag, " mem_en"},     32'(fpMemEn),     32'(|expGrant));
        compare({tag, " mem_addr"},   32'(fpMemAddr),   expGrant[0] ? 32'h3 : (expGrant[1] ? 32'h4 : 32'h0));
        compare({tag, " resp_valid"}, 32'(fpRespValid), 32'(expResp));
        if (expResp != 2'b00 || rstFp) begin
            compare({tag, " resp_rdata"}, fpRespRdata, expRdata);
        end
    endtask

    initial begin
        nVectors = 0; nMiscompares = 0; nCompares = 0;
        preload = 1'b1;
        rstRr = 1'b1; rrEn = '0; rrWe = '0;
        rrAddr  = {13'h020, 13'h010, 13'h005};
        rrBe    = {4'hF, 4'hF, 4'h3};
        rrWdata = {32'h55667788, 32'h0BADF00D, 32'h11223344};
        rstFp = 1'b1; fpEn = '0; fpWe = '0;
        fpAddr  = {13'h004, 13'h003};
        fpBe    = 8'hFF;
        fpWdata = {32'h0000FFFF, 32'hFFFF0000};

        //            rst   en      we      grant   resp    rdata
        vecs[0]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 32'h0};
        vecs[1]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0};
        vecs[2]  = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b000, 32'h0};
        vecs[3]  = '{1'b0, 3'b111, 3'b000, 3'b010, 3'b000, 32'h0};
        vecs[4]  = '{1'b0, 3'b111, 3'b000, 3'b100, 3'b001, 32'hAAAAAAAA};
        vecs[5]  = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b010, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 3'b111, 3'b000, 3'b010, 3'b100, 32'h22222222};
        vecs[7]  = '{1'b0, 3'b111, 3'b000, 3'b100, 3'b001, 32'hAAAAAAAA};
        vecs[8]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 32'h22222222};
        vecs[10] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0};
        vecs[11] = '{1'b0, 3'b010, 3'b000, 3'b010, 3'b000, 32'h0};
        vecs[12] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0};
        vecs[13] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 32'hDEADBEEF};
        vecs[14] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0};
        vecs[15] = '{1'b0, 3'b101, 3'b000, 3'b100, 3'b000, 32'h0};
        vecs[16] = '{1'b0, 3'b001, 3'b000, 3'b001, 3'b000, 32'h0};
        vecs[17] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 32'h22222222};
        vecs[18] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 32'hAAAAAAAA};
        vecs[19] = '{1'b0, 3'b001, 3'b001, 3'b001, 3'b000, 32'h0};
        vecs[20] = '{1'b0, 3'b001, 3'b000, 3'b001, 3'b000, 32'h0};
        vecs[21] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0};
        vecs[22] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 32'hAAAA3344};
        vecs[23] = '{1'b0, 3'b010, 3'b000, 3'b010, 3'b000, 32'h0};
        vecs[24] = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 32'h0};
        vecs[25] = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b000, 32'h0};
        vecs[26] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 32'h0};
        vecs[27] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 32'hAAAA3344};
        vecs[28] = '{1'b0, 3'b100, 3'b100, 3'b100, 3'b000, 32'h0};
        vecs[29] = '{1'b0, 3'b110, 3'b000, 3'b010, 3'b000, 32'h0};
        vecs[30] = '{1'b0, 3'b100, 3'b000, 3'b100, 3'b000, 32'h0};
        vecs[31] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 32'hDEADBEEF};
        vecs[32] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 32'h55667788};

        @(posedge clk);
        #1;
        preload = 1'b0;

        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Fixed priority: port 1 starves while port 0 requests, then wins in the cycle port 0 drops
        applyStimulusFp(1'b1, 2'b11); checkOutputFp(0, 2'b00, 2'b00, 32'h0);
        applyStimulusFp(1'b0, 2'b11); checkOutputFp(1, 2'b01, 2'b00, 32'h0);
        applyStimulusFp(1'b0, 2'b11); checkOutputFp(2, 2'b01, 2'b01, 32'h33333333);
        applyStimulusFp(1'b0, 2'b11); checkOutputFp(3, 2'b01, 2'b01, 32'h33333333);
        applyStimulusFp(1'b0, 2'b10); checkOutputFp(4, 2'b10, 2'b01, 32'h33333333);
        applyStimulusFp(1'b0, 2'b00); checkOutputFp(5, 2'b00, 2'b10, 32'h44444444);
        applyStimulusFp(1'b0, 2'b00); checkOutputFp(6, 2'b00, 2'b00, 32'h0);
        applyStimulusFp(1'b0, 2'b10); checkOutputFp(7, 2'b10, 2'b00, 32'h0);
        applyStimulusFp(1'b0, 2'b00); checkOutputFp(8, 2'b00, 2'b10, 32'h44444444);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
